eth_uart_bridge: RTL and testbench

FPGA top-level bridge between a UART command port and two RMII Ethernet PHYs. A byte received on UART is sent as a minimal Ethernet frame on PHY1. A frame received on PHY1 has its payload byte latched to the LEDs and echoed on UART TX. PHY2 is idle; it is powered, clocked and held out of reset.

---
 rtl/eth_uart_bridge.sv | 338 +++++++++++++++++++++++++++++++++
 tb/tb_eth_uart_bridge.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_uart_bridge.sv
// UART <-> RMII bridge: UART bytes go out as minimal frames on PHY1,
// PHY1 frame payloads land on the LEDs and are echoed on UART.
module eth_uart_bridge #(
  parameter int CLKS_PER_BIT   = 1736,
  parameter int PREAMBLE_BYTES = 7,
  parameter int IFG_DIBITS     = 48
) (
  input  logic       clk_200_mhz,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       uart_tx,
  input  logic       crs_dv_1,
  input  logic       rx_er_1,
  input  logic [1:0] rx_d_1,
  output logic [1:0] tx_d_1,
  output logic       tx_e_1,
  output logic       clk_50_mhz_1,
  output logic       rst_n_1,
  output logic       mdc_1,
  inout  wire        mdio_1,
  input  logic       crs_dv_2,
  input  logic       rx_er_2,
  input  logic [1:0] rx_d_2,
  output logic [1:0] tx_d_2,
  output logic       tx_e_2,
  output logic       clk_50_mhz_2,
  output logic       rst_n_2,
  output logic       mdc_2,
  inout  wire        mdio_2,
  input  logic       btn,
  output logic [7:0] led
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int PW = $clog2(PREAMBLE_BYTES + 1);
  localparam int IW = $clog2(IFG_DIBITS + 1);

  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] UR_IDLE  = 2'd0;
  localparam logic [1:0] UR_START = 2'd1;
  localparam logic [1:0] UR_DATA  = 2'd2;
  localparam logic [1:0] UR_STOP  = 2'd3;

  localparam logic [2:0] ET_IDLE = 3'd0;
  localparam logic [2:0] ET_PRE  = 3'd1;
  localparam logic [2:0] ET_SFD  = 3'd2;
  localparam logic [2:0] ET_DATA = 3'd3;
  localparam logic [2:0] ET_IFG  = 3'd4;

  localparam logic [1:0] ER_IDLE = 2'd0;
  localparam logic [1:0] ER_PRE  = 2'd1;
  localparam logic [1:0] ER_DATA = 2'd2;
  localparam logic [1:0] ER_WAIT = 2'd3;

  logic [1:0] ph;
  logic       tx_tick;
  logic       rx_tick;
  logic       rst_n_q;

  always_ff @(posedge clk_200_mhz) begin
    rst_n_q <= !rst;
    if (rst) ph <= 2'd0;
    else     ph <= ph + 2'd1;
  end

  assign tx_tick      = (ph == 2'd3);
  assign rx_tick      = (ph == 2'd1);
  assign clk_50_mhz_1 = ~ph[1];
  assign clk_50_mhz_2 = ~ph[1];
  assign rst_n_1      = rst_n_q;
  assign rst_n_2      = rst_n_q;
  assign mdc_1        = 1'b0;
  assign mdc_2        = 1'b0;
  assign mdio_1       = 1'bz;
  assign mdio_2       = 1'bz;
  assign tx_d_2       = 2'b00;
  assign tx_e_2       = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{crs_dv_2, rx_er_2, rx_d_2};

  // UART receive
  logic [1:0]    rx_sync;
  logic          rx_prev;
  logic          rx_s;
  logic [1:0]    ur_state;
  logic [CW-1:0] ur_cnt;
  logic [2:0]    ur_bits;
  logic [7:0]    ur_sh;
  logic          ur_valid;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk_200_mhz) begin
    if (rst) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      ur_state <= UR_IDLE;
      ur_cnt   <= '0;
      ur_bits  <= 3'd0;
      ur_sh    <= 8'h00;
      ur_valid <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], uart_rx};
      rx_prev  <= rx_s;
      ur_valid <= 1'b0;
      unique case (ur_state)
        UR_IDLE: begin
          ur_cnt <= '0;
          if (rx_prev && !rx_s) ur_state <= UR_START;
        end
        UR_START: begin
          if (ur_cnt == HALF_END) begin
            ur_cnt   <= '0;
            ur_bits  <= 3'd0;
            ur_state <= rx_s ? UR_IDLE : UR_DATA;
          end else begin
            ur_cnt <= ur_cnt + 1'b1;
          end
        end
        UR_DATA: begin
          if (ur_cnt == BIT_END) begin
            ur_cnt  <= '0;
            ur_sh   <= {ur_sh[6:0], rx_s};
            ur_bits <= ur_bits + 3'd1;
            if (ur_bits == 3'd7) ur_state <= UR_STOP;
          end else begin
            ur_cnt <= ur_cnt + 1'b1;
          end
        end
        UR_STOP: begin
          if (ur_cnt == BIT_END) begin
            ur_cnt   <= '0;
            ur_state <= UR_IDLE;
            ur_valid <= rx_s;
          end else begin
            ur_cnt <= ur_cnt + 1'b1;
          end
        end
        default: ur_state <= UR_IDLE;
      endcase
    end
  end

  logic [2:0] btn_sync;
  logic       btn_rise;

  always_ff @(posedge clk_200_mhz) begin
    if (rst) btn_sync <= 3'b000;
    else     btn_sync <= {btn_sync[1:0], btn};
  end

  assign btn_rise = btn_sync[1] & ~btn_sync[2];

  // Ethernet transmit; every trigger goes through the pending slot
  logic          trig;
  logic [7:0]    trig_d;
  logic [7:0]    last_byte;
  logic          pend_v;
  logic [7:0]    pend_d;
  logic [7:0]    cur;
  logic [2:0]    et_state;
  logic [1:0]    dcnt;
  logic [PW-1:0] bcnt;
  logic [IW-1:0] icnt;
  logic [7:0]    sel;

  assign trig   = ur_valid | btn_rise;
  assign trig_d = ur_valid ? ur_sh : last_byte;

  always_comb begin
    sel = cur;
    unique case (1'b1)
      (et_state == ET_PRE): sel = 8'h55;
      (et_state == ET_SFD): sel = 8'hD5;
      default:              sel = cur;
    endcase
  end

  always_ff @(posedge clk_200_mhz) begin
    if (rst) begin
      last_byte <= 8'h00;
      pend_v    <= 1'b0;
      pend_d    <= 8'h00;
      cur       <= 8'h00;
      et_state  <= ET_IDLE;
      dcnt      <= 2'd0;
      bcnt      <= '0;
      icnt      <= '0;
      tx_e_1    <= 1'b0;
      tx_d_1    <= 2'b00;
    end else begin
      if (ur_valid) last_byte <= ur_sh;
      if (tx_tick) begin
        unique case (et_state)
          ET_IDLE: begin
            tx_e_1 <= 1'b0;
            tx_d_1 <= 2'b00;
            dcnt   <= 2'd0;
            bcnt   <= '0;
            if (pend_v) begin
              cur      <= pend_d;
              pend_v   <= 1'b0;
              et_state <= ET_PRE;
            end
          end
          ET_PRE, ET_SFD, ET_DATA: begin
            tx_e_1 <= 1'b1;
            tx_d_1 <= 2'(sel >> {dcnt, 1'b0});
            dcnt   <= dcnt + 2'd1;
            if (dcnt == 2'd3) begin
              unique case (et_state)
                ET_PRE: begin
                  if (bcnt == PW'(PREAMBLE_BYTES - 1)) et_state <= ET_SFD;
                  else bcnt <= bcnt + 1'b1;
                end
                ET_SFD: et_state <= ET_DATA;
                default: begin
                  et_state <= ET_IFG;
                  icnt     <= '0;
                end
              endcase
            end
          end
          ET_IFG: begin
            tx_e_1 <= 1'b0;
            tx_d_1 <= 2'b00;
            if (icnt == IW'(IFG_DIBITS - 1)) et_state <= ET_IDLE;
            else icnt <= icnt + 1'b1;
          end
          default: et_state <= ET_IDLE;
        endcase
      end
      if (trig) begin
        pend_v <= 1'b1;
        pend_d <= trig_d;
      end
    end
  end

  // Ethernet receive
  logic [1:0] er_state;
  logic [1:0] er_prev;
  logic [7:0] er_sh;
  logic [1:0] er_cnt;
  logic       echo_v;

  always_ff @(posedge clk_200_mhz) begin
    if (rst) begin
      er_state <= ER_IDLE;
      er_prev  <= 2'b00;
      er_sh    <= 8'h00;
      er_cnt   <= 2'd0;
      led      <= 8'h00;
      echo_v   <= 1'b0;
    end else begin
      echo_v <= 1'b0;
      if (rx_tick) begin
        if (!crs_dv_1 || rx_er_1) begin
          er_state <= ER_IDLE;
        end else begin
          unique case (er_state)
            ER_IDLE: begin
              er_state <= ER_PRE;
              er_prev  <= rx_d_1;
            end
            ER_PRE: begin
              er_prev <= rx_d_1;
              er_cnt  <= 2'd0;
              if (er_prev == 2'b01 && rx_d_1 == 2'b11) er_state <= ER_DATA;
            end
            ER_DATA: begin
              er_sh  <= {rx_d_1, er_sh[7:2]};
              er_cnt <= er_cnt + 2'd1;
              if (er_cnt == 2'd3) begin
                led      <= {rx_d_1, er_sh[7:2]};
                echo_v   <= 1'b1;
                er_state <= ER_WAIT;
              end
            end
            default: er_state <= ER_WAIT;
          endcase
        end
      end
    end
  end

  // UART transmit with a one-deep holding register
  logic          hold_v;
  logic [7:0]    hold_d;
  logic          ut_busy;
  logic [7:0]    ut_sr;
  logic [CW-1:0] ut_cnt;
  logic [3:0]    ut_idx;

  always_ff @(posedge clk_200_mhz) begin
    if (rst) begin
      hold_v  <= 1'b0;
      hold_d  <= 8'h00;
      ut_busy <= 1'b0;
      ut_sr   <= 8'h00;
      ut_cnt  <= '0;
      ut_idx  <= 4'd0;
      uart_tx <= 1'b1;
    end else begin
      if (!ut_busy) begin
        if (hold_v) begin
          ut_busy <= 1'b1;
          ut_sr   <= hold_d;
          uart_tx <= 1'b0;
          ut_cnt  <= '0;
          ut_idx  <= 4'd0;
          hold_v  <= 1'b0;
        end
      end else if (ut_cnt == BIT_END) begin
        ut_cnt <= '0;
        ut_idx <= ut_idx + 4'd1;
        if (ut_idx == 4'd9) begin
          ut_busy <= 1'b0;
        end else if (ut_idx == 4'd8) begin
          uart_tx <= 1'b1;
        end else begin
          uart_tx <= ut_sr[7];
          ut_sr   <= {ut_sr[6:0], 1'b0};
        end
      end else begin
        ut_cnt <= ut_cnt + 1'b1;
      end
      if (echo_v) begin
        hold_v <= 1'b1;
        hold_d <= led;
      end
    end
  end

endmodule

// File: tb/tb_eth_uart_bridge.sv
// Scoreboard bench for eth_uart_bridge: queued frame and UART
// expectations checked by independent monitors.
module tb_eth_uart_bridge;

  localparam int CPB = 40;
  localparam int PRE = 7;
  localparam int IFG = 48;
  localparam int NDIB = 4 * (PRE + 2);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rx = 1'b1;
  logic btn = 1'b0;
  logic loop_en = 1'b1;
  logic m_crs = 1'b0;
  logic m_er = 1'b0;
  logic [1:0] m_d = 2'b00;
  logic mon_on = 1'b0;

  logic uart_tx;
  logic crs_dv_1, rx_er_1;
  logic [1:0] rx_d_1, tx_d_1;
  logic tx_e_1, clk_50_mhz_1, rst_n_1, mdc_1;
  logic [1:0] tx_d_2;
  logic tx_e_2, clk_50_mhz_2, rst_n_2, mdc_2;
  logic [7:0] led;
  wire mdio_1, mdio_2;

  assign crs_dv_1 = loop_en ? tx_e_1 : m_crs;
  assign rx_er_1  = loop_en ? !tx_e_1 : m_er;
  assign rx_d_1   = loop_en ? tx_d_1 : m_d;

  always #2.5 clk = ~clk;

  eth_uart_bridge #(
    .CLKS_PER_BIT(CPB),
    .PREAMBLE_BYTES(PRE),
    .IFG_DIBITS(IFG)
  ) dut (
    .clk_200_mhz(clk), .rst(rst),
    .uart_rx(uart_rx), .uart_tx(uart_tx),
    .crs_dv_1(crs_dv_1), .rx_er_1(rx_er_1), .rx_d_1(rx_d_1),
    .tx_d_1(tx_d_1), .tx_e_1(tx_e_1),
    .clk_50_mhz_1(clk_50_mhz_1), .rst_n_1(rst_n_1),
    .mdc_1(mdc_1), .mdio_1(mdio_1),
    .crs_dv_2(1'b0), .rx_er_2(1'b0), .rx_d_2(2'b00),
    .tx_d_2(tx_d_2), .tx_e_2(tx_e_2),
    .clk_50_mhz_2(clk_50_mhz_2), .rst_n_2(rst_n_2),
    .mdc_2(mdc_2), .mdio_2(mdio_2),
    .btn(btn), .led(led)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] frame_q[$];
  logic [7:0] uart_q[$];
  logic [7:0] led_m = 8'h00;
  logic [7:0] last_m = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Frame on the wire: PRE x 0x55, 0xD5, payload, each LSB dibit first
  function automatic logic [1:0] exp_dibit(input int k, input logic [7:0] p);
    logic [7:0] b;
    b = (k < 4 * PRE) ? 8'h55 : (k < 4 * PRE + 4) ? 8'hD5 : p;
    return b[2 * (k % 4) +: 2];
  endfunction

  initial begin : frame_mon
    logic [1:0] dq[$];
    int gap, herr;
    bit seen, inf;
    logic c50p;
    logic [7:0] p, obs;
    gap = 0; seen = 0; inf = 0; c50p = 1'b1;
    forever begin
      @(negedge clk);
      if (rst || !mon_on) begin
        dq.delete(); inf = 0; seen = 0; gap = 0;
        c50p = clk_50_mhz_1;
        continue;
      end
      if (clk_50_mhz_1 && !c50p) begin
        if (tx_e_1) begin
          if (!inf) begin
            if (seen) begin
              n_chk++;
              if (gap < IFG) begin
                n_fail++;
                $display("FAIL ifg_gap: %0d idle slots, expected >= %0d", gap, IFG);
              end
            end
            inf = 1;
            dq.delete();
          end
          dq.push_back(tx_d_1);
        end else if (inf) begin
          inf = 0; seen = 1; gap = 1;
          if (frame_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL frame_unexpected: got %0d dibits, expected none", dq.size());
          end else begin
            p = frame_q.pop_front();
            herr = 0; obs = 8'h00;
            for (int k = 0; k < dq.size() && k < NDIB; k++) begin
              if (k < NDIB - 4) herr += (dq[k] != exp_dibit(k, p)) ? 1 : 0;
              else obs[2 * (k - (NDIB - 4)) +: 2] = dq[k];
            end
            chk("frame_len", dq.size(), NDIB);
            chk("frame_hdr_errs", herr, 0);
            chk("frame_payload", obs, p);
          end
        end else begin
          gap++;
        end
      end
      c50p = clk_50_mhz_1;
    end
  end

  initial begin : uart_mon
    logic [7:0] b;
    logic [7:0] e;
    logic sb;
    forever begin
      @(negedge uart_tx);
      if (!mon_on || rst) continue;
      repeat (CPB / 2) @(posedge clk);
      #1;
      chk("uart_start", uart_tx, 1'b0);
      for (int i = 7; i >= 0; i--) begin
        repeat (CPB) @(posedge clk);
        #1;
        b[i] = uart_tx;
      end
      repeat (CPB) @(posedge clk);
      #1;
      sb = uart_tx;
      chk("uart_stop", sb, 1'b1);
      if (uart_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL uart_unexpected: got 0x%0h, expected nothing", b);
      end else begin
        e = uart_q.pop_front();
        chk("uart_byte", b, e);
      end
    end
  end

  task automatic send_uart(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 7; i >= 0; i--) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    frame_q.push_back(b);
    uart_q.push_back(b);
    last_m = b;
    led_m = b;
    send_uart(b, 1'b1);
  endtask

  task automatic pulse_btn();
    frame_q.push_back(last_m);
    uart_q.push_back(last_m);
    led_m = last_m;
    @(negedge clk);
    btn = 1'b1;
    repeat (8) @(negedge clk);
    btn = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while ((frame_q.size() != 0 || uart_q.size() != 0) && t < 30000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 30000) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: %0d frames, %0d uart bytes outstanding, expected 0",
               nm, frame_q.size(), uart_q.size());
      frame_q.delete();
      uart_q.delete();
    end
    repeat (2 * CPB) @(posedge clk);
  endtask

  task automatic slot();
    @(posedge clk_50_mhz_1);
    @(negedge clk);
  endtask

  task automatic drive_frame(input logic [7:0] p, input int n, input int er_at);
    for (int k = 0; k < n; k++) begin
      slot();
      m_crs = 1'b1;
      m_er = (k == er_at);
      m_d = (k < NDIB) ? exp_dibit(k, p) : 2'($urandom);
    end
    slot();
    m_crs = 1'b0; m_er = 1'b0; m_d = 2'b00;
    repeat (20) slot();
  endtask

  initial begin : main
    logic [7:0] b;
    logic [7:0] seq[6];
    int t;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_n_1_in_reset", rst_n_1, 1'b0);
    chk("rst_n_2_in_reset", rst_n_2, 1'b0);
    chk("uart_tx_reset", uart_tx, 1'b1);
    chk("tx_e_1_reset", tx_e_1, 1'b0);
    chk("tx_d_1_reset", tx_d_1, 2'b00);
    chk("led_reset", led, 8'h00);
    chk("phy2_tx_idle", {tx_e_2, tx_d_2, mdc_1, mdc_2}, 5'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_n_1_run", rst_n_1, 1'b1);
    chk("rst_n_2_run", rst_n_2, 1'b1);
    mon_on = 1'b1;

    send_good(8'h19);
    wait_idle("first");
    chk("led_0x19", led, led_m);

    pulse_btn();
    wait_idle("btn");
    chk("led_after_btn", led, led_m);

    // second press lands mid-frame and must wait out the IFG
    pulse_btn();
    repeat (60) @(negedge clk);
    pulse_btn();
    wait_idle("btn_pending");

    seq[0] = 8'hA5;
    seq[1] = 8'h3C;
    for (int i = 2; i < 6; i++) seq[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      send_good(seq[i]);
      repeat ($urandom_range(5, 30)) @(negedge clk);
      if (i == 1) begin
        wait_idle("a5_3c");
        chk("led_0x3c", led, 8'h3C);
      end
    end
    wait_idle("random");
    chk("led_random", led, led_m);

    send_uart(8'($urandom), 1'b0);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    chk("led_bad_uart", led, led_m);
    pulse_btn();
    wait_idle("btn_after_bad");

    loop_en = 1'b0;
    b = 8'($urandom);
    if (b == led_m) b = ~b;
    drive_frame(b, NDIB, NDIB - 2);
    chk("led_rx_er", led, led_m);
    drive_frame(b, NDIB - 2, -1);
    chk("led_truncated", led, led_m);
    uart_q.push_back(b);
    led_m = b;
    drive_frame(b, NDIB + 3, -1);
    wait_idle("manual_rx");
    chk("led_manual", led, led_m);
    loop_en = 1'b1;

    send_uart(8'($urandom), 1'b1);
    t = 0;
    while (!tx_e_1 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    chk("tx_start_before_rst", tx_e_1, 1'b1);
    repeat (40) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("tx_e_1_after_rst", tx_e_1, 1'b0);
    chk("uart_tx_after_rst", uart_tx, 1'b1);
    @(posedge clk);
    #1;
    chk("rst_n_1_mid_rst", rst_n_1, 1'b0);
    chk("rst_n_2_mid_rst", rst_n_2, 1'b0);
    chk("led_mid_rst", led, 8'h00);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    led_m = 8'h00;
    last_m = 8'h00;
    repeat (400) @(negedge clk);
    chk("led_post_rst", led, 8'h00);
    pulse_btn();
    wait_idle("btn_post_rst");
    chk("led_btn_zero", led, 8'h00);

    chk("frames_left", frame_q.size(), 0);
    chk("uart_left", uart_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
